// File: rtl/vme_pkg.sv
// Shared constants and types for the VME device-bus sequencer and its VME top level.
package vme_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SETUP    = 3'd1,
      S_STROBE   = 3'd2,
      S_HOLD     = 3'd3,
      S_COMPLETE = 3'd4
   } state_e;

   localparam logic [15:0] BUS_ERR_DATA = 16'hDEAD;
   localparam int          TIMER_W      = 10;

   localparam logic [3:0] DEV_STATUS  = 4'd0;
   localparam logic [3:0] DEV_CONTROL = 4'd1;
   localparam logic [3:0] DEV_FLASH   = 4'd2;
   localparam logic [3:0] DEV_TEMP    = 4'd3;

   typedef struct packed {
      logic        write_b;
      logic [3:0]  dev;
      logic [9:0]  cmd;
      logic [15:0] wdata;
   } req_t;

endpackage

// File: rtl/vme_cycle_timer.sv
// Loadable cycle counter: counts down to zero or up towards a limit, saturating both ways.
// The count updates the cycle after load/en; term_o is decoded from the current count.
module vme_cycle_timer #(
   parameter int W = 10
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   input  logic         up_i,
   input  logic [W-1:0] limit_i,
   output logic         term_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         if (up_i) begin
            if (cnt_q != '1) cnt_d = cnt_q + W'(1);
         end else begin
            if (cnt_q != '0) cnt_d = cnt_q - W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // Up mode flags the cycle whose increment reaches the limit, so the caller reacts on that same edge.
   assign term_o = up_i ? (({1'b0, cnt_q} + (W+1)'(1)) >= {1'b0, limit_i})
                        : (cnt_q == '0);

endmodule

// File: rtl/vme_dev_sequencer.sv
// Runs one VME slave access on the DMB device bus: decode, setup, strobe, hold, DONE with read data.
// STROBE rises SETUP_CYC+1 cycles after REQ is accepted; REQ/DONE is a level handshake and a silent slave times out.
module vme_dev_sequencer
   import vme_pkg::*;
#(
   parameter int NDEV        = 8,
   parameter int SETUP_CYC   = 2,
   parameter int TIMEOUT_CYC = 200
) (
   input  logic            FASTCLK,
   input  logic            RST,
   input  logic            REQ,
   input  logic            REQ_WRITE_B,
   input  logic [3:0]      REQ_DEV,
   input  logic [9:0]      REQ_CMD,
   input  logic [15:0]     REQ_WDATA,
   output logic [NDEV-1:0] DEVICE,
   output logic            STROBE,
   output logic            WRITE_B,
   output logic [9:0]      COMMAND,
   output logic [15:0]     INDATA,
   input  logic [NDEV-1:0] SLV_ACK,
   input  logic [15:0]     SLV_RDATA,
   output logic            DONE,
   output logic [15:0]     RDATA,
   output logic            TIMEOUT,
   output logic            BUSY
);

   state_e          state_q;
   logic [NDEV-1:0] device_q;
   logic            strobe_q;
   logic            write_b_q;
   logic [9:0]      command_q;
   logic [15:0]     indata_q;
   logic            done_q;
   logic [15:0]     rdata_q;
   logic            timeout_q;
   logic            busy_q;
   logic            req_low_q;

   req_t            req;
   logic            accept;
   logic            dev_mapped;
   logic [NDEV-1:0] dev_onehot;
   logic            ack_hit;
   logic            setup_term;
   logic            tmo_term;

   assign req = '{write_b: REQ_WRITE_B, dev: REQ_DEV, cmd: REQ_CMD, wdata: REQ_WDATA};

   // Only a fresh REQ assertion starts a cycle, so a level left high across reset or DONE is ignored.
   assign accept     = (state_q == S_IDLE) && REQ && req_low_q;
   assign dev_mapped = 32'(req.dev) < NDEV;
   assign dev_onehot = NDEV'(1) << req.dev;
   assign ack_hit    = |(SLV_ACK & device_q);

   vme_cycle_timer #(.W(TIMER_W)) u_setup_tmr (
      .clk_i      (FASTCLK),
      .rst_i      (RST),
      .load_i     (accept),
      .load_val_i (TIMER_W'(SETUP_CYC)),
      .en_i       (state_q == S_SETUP),
      .up_i       (1'b0),
      .limit_i    ('0),
      .term_o     (setup_term)
   );

   vme_cycle_timer #(.W(TIMER_W)) u_tmo_tmr (
      .clk_i      (FASTCLK),
      .rst_i      (RST),
      .load_i     ((state_q == S_SETUP) && setup_term),
      .load_val_i ('0),
      .en_i       (state_q == S_STROBE),
      .up_i       (1'b1),
      .limit_i    (TIMER_W'(TIMEOUT_CYC)),
      .term_o     (tmo_term)
   );

   always_ff @(posedge FASTCLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         device_q  <= '0;
         strobe_q  <= 1'b0;
         write_b_q <= 1'b1;
         command_q <= '0;
         indata_q  <= '0;
         done_q    <= 1'b0;
         rdata_q   <= '0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
         req_low_q <= 1'b0;
      end else begin
         req_low_q <= ~REQ;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  busy_q <= 1'b1;
                  if (dev_mapped) begin
                     state_q   <= S_SETUP;
                     device_q  <= dev_onehot;
                     write_b_q <= req.write_b;
                     command_q <= req.cmd;
                     indata_q  <= req.wdata;
                  end else begin
                     state_q   <= S_COMPLETE;
                     done_q    <= 1'b1;
                     timeout_q <= 1'b1;
                     rdata_q   <= BUS_ERR_DATA;
                  end
               end
            end
            S_SETUP: begin
               if (setup_term) begin
                  state_q  <= S_STROBE;
                  strobe_q <= 1'b1;
               end
            end
            S_STROBE: begin
               // Acknowledge is tested first so an ACK on the terminal cycle still wins.
               if (ack_hit) begin
                  state_q  <= S_HOLD;
                  strobe_q <= 1'b0;
                  if (write_b_q) rdata_q <= SLV_RDATA;
               end else if (tmo_term) begin
                  state_q   <= S_HOLD;
                  strobe_q  <= 1'b0;
                  rdata_q   <= BUS_ERR_DATA;
                  timeout_q <= 1'b1;
               end
            end
            S_HOLD: begin
               state_q   <= S_COMPLETE;
               device_q  <= '0;
               write_b_q <= 1'b1;
               command_q <= '0;
               indata_q  <= '0;
               done_q    <= 1'b1;
            end
            S_COMPLETE: begin
               if (!REQ) begin
                  state_q   <= S_IDLE;
                  done_q    <= 1'b0;
                  timeout_q <= 1'b0;
                  busy_q    <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign DEVICE  = device_q;
   assign STROBE  = strobe_q;
   assign WRITE_B = write_b_q;
   assign COMMAND = command_q;
   assign INDATA  = indata_q;
   assign DONE    = done_q;
   assign RDATA   = rdata_q;
   assign TIMEOUT = timeout_q;
   assign BUSY    = busy_q;

endmodule

// File: tb/tb_vme_dev_sequencer.sv
// Bench for vme_dev_sequencer: directed vector table, reset-abort sequence and randomized accesses vs an outcome model.
module tb_vme_dev_sequencer;

   localparam int NDEV        = 8;
   localparam int SETUP_CYC   = 2;
   localparam int TIMEOUT_CYC = 200;
   localparam int BUDGET      = SETUP_CYC + TIMEOUT_CYC + 20;
   localparam int NTBL        = 11;

   logic            FASTCLK = 1'b0;
   logic            RST;
   logic            REQ;
   logic            REQ_WRITE_B;
   logic [3:0]      REQ_DEV;
   logic [9:0]      REQ_CMD;
   logic [15:0]     REQ_WDATA;
   logic [NDEV-1:0] DEVICE;
   logic            STROBE;
   logic            WRITE_B;
   logic [9:0]      COMMAND;
   logic [15:0]     INDATA;
   logic [NDEV-1:0] SLV_ACK;
   logic [15:0]     SLV_RDATA;
   logic            DONE;
   logic [15:0]     RDATA;
   logic            TIMEOUT;
   logic            BUSY;

   int applied     = 0;
   int miscompares = 0;

   typedef struct {
      bit wb;
      int dev;
      int cmd;
      int wdata;
      int ack_dly;
      int ack_data;
      int wrong_dev;
      int wrong_dly;
      bit drop_early;
      int hold_cyc;
   } txn_t;

   typedef struct {
      int lat;
      int width;
      int done_lat;
      int to;
      int rdata;
   } res_t;

   typedef struct {
      txn_t t;
      res_t e;
   } vec_t;

   vme_dev_sequencer #(
      .NDEV        (NDEV),
      .SETUP_CYC   (SETUP_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .FASTCLK     (FASTCLK),
      .RST         (RST),
      .REQ         (REQ),
      .REQ_WRITE_B (REQ_WRITE_B),
      .REQ_DEV     (REQ_DEV),
      .REQ_CMD     (REQ_CMD),
      .REQ_WDATA   (REQ_WDATA),
      .DEVICE      (DEVICE),
      .STROBE      (STROBE),
      .WRITE_B     (WRITE_B),
      .COMMAND     (COMMAND),
      .INDATA      (INDATA),
      .SLV_ACK     (SLV_ACK),
      .SLV_RDATA   (SLV_RDATA),
      .DONE        (DONE),
      .RDATA       (RDATA),
      .TIMEOUT     (TIMEOUT),
      .BUSY        (BUSY)
   );

   always #5 FASTCLK = ~FASTCLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Outcome of one access from the access rules alone: latency, strobe width, flags and data.
   function automatic res_t model(input txn_t t, input int prev_rdata);
      res_t r;
      if (t.dev >= NDEV) begin
         r.lat = -1; r.width = 0; r.done_lat = 0; r.to = 1; r.rdata = 'hDEAD;
      end else begin
         r.lat = SETUP_CYC + 1;
         if (t.ack_dly > 0 && t.ack_dly <= TIMEOUT_CYC) begin
            r.width = t.ack_dly;
            r.to    = 0;
            r.rdata = t.wb ? t.ack_data : prev_rdata;
         end else begin
            r.width = TIMEOUT_CYC;
            r.to    = 1;
            r.rdata = 'hDEAD;
         end
         r.done_lat = r.lat + r.width + 1;
      end
      return r;
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, ":DEVICE"},  32'(DEVICE),  0);
      chk({tag, ":STROBE"},  32'(STROBE),  0);
      chk({tag, ":WRITE_B"}, 32'(WRITE_B), 1);
      chk({tag, ":COMMAND"}, 32'(COMMAND), 0);
      chk({tag, ":INDATA"},  32'(INDATA),  0);
      chk({tag, ":DONE"},    32'(DONE),    0);
      chk({tag, ":RDATA"},   32'(RDATA),   0);
      chk({tag, ":TIMEOUT"}, 32'(TIMEOUT), 0);
      chk({tag, ":BUSY"},    32'(BUSY),    0);
   endtask

   // Drives one access, plays the addressed slave, and checks the outcome against e.
   task automatic do_txn(input txn_t t, input res_t e, input string tag);
      int              cyc;
      int              sw;
      int              lat;
      int              done_lat;
      bit              hold_ok;
      bit              rel_ok;
      bit              busy_ok;
      bit              held_ok;
      logic [NDEV-1:0] onehot;

      onehot = '0;
      if (t.dev < NDEV) onehot[t.dev] = 1'b1;

      @(negedge FASTCLK);
      REQ     = 1'b0;
      SLV_ACK = '0;
      @(negedge FASTCLK);
      REQ         = 1'b1;
      REQ_WRITE_B = t.wb;
      REQ_DEV     = 4'(t.dev);
      REQ_CMD     = 10'(t.cmd);
      REQ_WDATA   = 16'(t.wdata);
      @(negedge FASTCLK);

      cyc = 0; sw = 0; lat = -1; done_lat = -1;
      hold_ok = 1'b1; rel_ok = 1'b0; busy_ok = 1'b1;
      while (cyc < BUDGET) begin
         busy_ok &= (BUSY === 1'b1);
         if (DONE === 1'b1) begin
            done_lat = cyc;
            rel_ok   = (DEVICE === '0) && (STROBE === 1'b0) && (WRITE_B === 1'b1);
            break;
         end
         if (t.dev < NDEV)
            hold_ok &= (DEVICE === onehot) && (WRITE_B === t.wb) &&
                       (COMMAND === 10'(t.cmd)) && (INDATA === 16'(t.wdata));
         else
            hold_ok &= (DEVICE === '0) && (STROBE === 1'b0);
         if (STROBE === 1'b1) begin
            sw++;
            if (lat < 0) lat = cyc;
         end
         SLV_ACK   = '0;
         SLV_RDATA = 16'($urandom_range(0, 65535));
         if (STROBE === 1'b1 && t.dev < NDEV && t.ack_dly > 0 && sw == t.ack_dly) begin
            SLV_ACK[t.dev] = 1'b1;
            SLV_RDATA      = 16'(t.ack_data);
         end
         if (STROBE === 1'b1 && t.wrong_dly > 0 && sw == t.wrong_dly)
            SLV_ACK[t.wrong_dev] = 1'b1;
         if (t.drop_early && cyc == 1) REQ = 1'b0;
         @(negedge FASTCLK);
         cyc++;
      end
      SLV_ACK = '0;

      chk({tag, ":done_lat"},   32'(done_lat), 32'(e.done_lat));
      chk({tag, ":strobe_lat"}, 32'(lat),      32'(e.lat));
      chk({tag, ":strobe_w"},   32'(sw),       32'(e.width));
      chk({tag, ":timeout"},    32'(TIMEOUT),  32'(e.to));
      chk({tag, ":rdata"},      32'(RDATA),    32'(e.rdata));
      chk({tag, ":bus_stable"}, 32'(hold_ok),  1);
      chk({tag, ":released"},   32'(rel_ok),   1);
      chk({tag, ":busy"},       32'(busy_ok),  1);

      if (!t.drop_early && t.hold_cyc > 0) begin
         held_ok = 1'b1;
         for (int i = 0; i < t.hold_cyc; i++) begin
            @(negedge FASTCLK);
            held_ok &= (DONE === 1'b1) && (STROBE === 1'b0) && (BUSY === 1'b1) && (DEVICE === '0);
         end
         chk({tag, ":req_held"}, 32'(held_ok), 1);
      end
      REQ = 1'b0;
      @(negedge FASTCLK);
      chk({tag, ":done_clr"},   32'(DONE),    0);
      chk({tag, ":to_clr"},     32'(TIMEOUT), 0);
      chk({tag, ":busy_clr"},   32'(BUSY),    0);
      chk({tag, ":rdata_keep"}, 32'(RDATA),   32'(e.rdata));
   endtask

   initial begin
      vec_t tbl [NTBL];
      txn_t t;
      res_t e;
      int   model_rd;
      int   n;
      bit   quiet;

      //             wb    dev cmd    wdata    ack  ack_data wdev wdly drop hold     lat width done to rdata
      tbl[0]  = '{'{1'b1,  3,  0,     0,       3,   'h7E1C,  0,   0,   1'b0, 0}, '{ 3,   3,    7, 0, 'h7E1C}};
      tbl[1]  = '{'{1'b0,  1,  2,     'hA5A5,  2,   'h1234,  0,   0,   1'b0, 0}, '{ 3,   2,    6, 0, 'h7E1C}};
      tbl[2]  = '{'{1'b1,  5,  'h3FF, 0,       0,   0,       0,   0,   1'b0, 0}, '{ 3,   200, 204, 1, 'hDEAD}};
      tbl[3]  = '{'{1'b1,  12, 1,     0,       1,   'h1111,  0,   0,   1'b0, 0}, '{-1,   0,    0, 1, 'hDEAD}};
      tbl[4]  = '{'{1'b1,  4,  7,     0,       5,   'h4444,  2,   1,   1'b0, 0}, '{ 3,   5,    9, 0, 'h4444}};
      tbl[5]  = '{'{1'b1,  4,  7,     0,       0,   0,       2,   2,   1'b0, 0}, '{ 3,   200, 204, 1, 'hDEAD}};
      tbl[6]  = '{'{1'b1,  0,  9,     0,       200, 'hBEEF,  0,   0,   1'b0, 0}, '{ 3,   200, 204, 0, 'hBEEF}};
      tbl[7]  = '{'{1'b1,  6,  9,     0,       201, 'hCAFE,  0,   0,   1'b0, 0}, '{ 3,   200, 204, 1, 'hDEAD}};
      tbl[8]  = '{'{1'b0,  7,  'h155, 'h5A5A,  1,   'h9999,  0,   0,   1'b1, 0}, '{ 3,   1,    5, 0, 'hDEAD}};
      tbl[9]  = '{'{1'b1,  8,  4,     0,       1,   'h2222,  0,   0,   1'b0, 4}, '{-1,   0,    0, 1, 'hDEAD}};
      tbl[10] = '{'{1'b1,  2,  'h2AA, 0,       1,   'h0F0F,  5,   1,   1'b0, 3}, '{ 3,   1,    5, 0, 'h0F0F}};

      RST = 1'b1; REQ = 1'b0; REQ_WRITE_B = 1'b1; REQ_DEV = '0; REQ_CMD = '0; REQ_WDATA = '0;
      SLV_ACK = '0; SLV_RDATA = '0;
      repeat (3) @(negedge FASTCLK);
      RST = 1'b0;
      check_reset("por");

      for (int i = 0; i < NTBL; i++) begin
         do_txn(tbl[i].t, tbl[i].e, $sformatf("vec%0d", i));
      end
      model_rd = tbl[NTBL-1].e.rdata;

      // Reset while STROBE is up, with REQ left asserted: nothing may restart until REQ toggles.
      @(negedge FASTCLK);
      REQ = 1'b0;
      @(negedge FASTCLK);
      REQ = 1'b1; REQ_WRITE_B = 1'b1; REQ_DEV = 4'd2; REQ_CMD = 10'h15; REQ_WDATA = 16'h0;
      n = 0;
      while (STROBE !== 1'b1 && n < BUDGET) begin
         @(negedge FASTCLK);
         n++;
      end
      chk("rst:strobe_seen", 32'(STROBE), 1);
      RST = 1'b1;
      @(negedge FASTCLK);
      RST = 1'b0;
      check_reset("rst_mid");
      quiet = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge FASTCLK);
         quiet &= (DONE === 1'b0) && (BUSY === 1'b0) && (STROBE === 1'b0) && (DEVICE === '0);
      end
      chk("rst:req_held_quiet", 32'(quiet), 1);
      model_rd = 0;
      t = '{1'b1, 2, 'h15, 0, 4, 'h1357, 0, 0, 1'b0, 0};
      e = model(t, model_rd);
      do_txn(t, e, "rst:restart");
      model_rd = e.rdata;

      for (int k = 0; k < 24; k++) begin
         t.wb       = ($urandom_range(0, 1) == 1);
         t.dev      = $urandom_range(0, 9);
         t.cmd      = $urandom_range(0, 1023);
         t.wdata    = $urandom_range(0, 65535);
         t.ack_data = $urandom_range(0, 65535);
         case ($urandom_range(0, 9))
            0:       t.ack_dly = 0;
            1:       t.ack_dly = TIMEOUT_CYC;
            default: t.ack_dly = $urandom_range(1, 8);
         endcase
         t.wrong_dev  = (t.dev + $urandom_range(1, NDEV - 1)) % NDEV;
         t.wrong_dly  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0;
         t.drop_early = ($urandom_range(0, 3) == 0);
         t.hold_cyc   = $urandom_range(0, 3);
         e = model(t, model_rd);
         do_txn(t, e, $sformatf("rnd%0d", k));
         model_rd = e.rdata;
      end

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule

// File: doc/vme_dev_sequencer.md
Name: vme_dev_sequencer

Overview:
Sequences one VME slave cycle at a time onto the internal device bus shared by the DMB status/control slaves. It decodes the device field, drives DEVICE/STROBE/WRITE_B/COMMAND/INDATA with setup and hold timing, waits for the addressed slave's acknowledge, captures read data and returns a single DTACK to the bus interface. A timeout watchdog guarantees that an unanswered access still completes, with an error flag, so the VME master is never hung.

Parameters:
NDEV, 8, number of device selects; device field is 4 bits, and values >= NDEV are unmapped.
SETUP_CYC, 2, FASTCLK cycles between DEVICE/COMMAND valid and STROBE assertion (1..15).
TIMEOUT_CYC, 200, FASTCLK cycles of STROBE with no acknowledge before the cycle is aborted (1..1023).

Ports:
FASTCLK  in  1  system clock; all logic on posedge.
RST  in  1  synchronous, active-high reset.
REQ  in  1  cycle request from bus interface; level, held until DONE is seen.
REQ_WRITE_B  in  1  0 = write, 1 = read; sampled at acceptance.
REQ_DEV  in  4  device number.
REQ_CMD  in  10  command field.
REQ_WDATA  in  16  write data.
DEVICE  out  NDEV  one-hot device select.
STROBE  out  1  data strobe to slaves.
WRITE_B  out  1  direction to slaves.
COMMAND  out  10  command to slaves.
INDATA  out  16  write data to slaves.
SLV_ACK  in  NDEV  per-device acknowledge, active-high (internal, non-tristate form of each slave's DTACK_B).
SLV_RDATA  in  16  resolved read data from the slaves.
DONE  out  1  cycle complete; held until REQ drops.
RDATA  out  16  captured read data; valid while DONE.
TIMEOUT  out  1  set with DONE when the cycle was aborted.
BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (RST high at a posedge): state IDLE. DEVICE=0, STROBE=0, WRITE_B=1, COMMAND=0, INDATA=0, DONE=0, RDATA=0, TIMEOUT=0, BUSY=0. Counters cleared. Reset mid-cycle aborts immediately, with no DONE.
- All outputs are registered.
- IDLE: on REQ=1, latch REQ_WRITE_B, REQ_DEV, REQ_CMD and REQ_WDATA.
  - Mapped device (REQ_DEV < NDEV): go to SETUP. DEVICE = one-hot of REQ_DEV, COMMAND, WRITE_B and INDATA driven from the latched values, BUSY=1.
  - Unmapped device: go directly to COMPLETE with TIMEOUT=1 and RDATA=16'hDEAD.
- SETUP: count SETUP_CYC cycles, then go to STROBE and assert STROBE. STROBE therefore first rises SETUP_CYC+1 cycles after REQ is sampled.
- STROBE: STROBE=1. The timeout counter increments every cycle.
  - Acknowledge: when SLV_ACK[dev]=1, capture RDATA = SLV_RDATA (reads only; RDATA unchanged on writes), drop STROBE and go to HOLD.
  - Timeout: if the counter reaches TIMEOUT_CYC first, drop STROBE, set RDATA=16'hDEAD and TIMEOUT=1, and go to HOLD.
  - Only the selected device's ACK is honoured. ACK from any other device is ignored.
  - ACK arriving in the same cycle the counter reaches TIMEOUT_CYC: the ACK wins and TIMEOUT=0.
- HOLD: one cycle. DEVICE, COMMAND and INDATA are kept stable after STROBE falls, then all are released: DEVICE=0, WRITE_B=1. Go to COMPLETE.
- COMPLETE: DONE=1. Stay until REQ=0, then clear DONE and TIMEOUT and return to IDLE.
  - A new cycle needs REQ to deassert and reassert; REQ held high never restarts a cycle.
  - RDATA holds its value until the next capture.
- REQ dropping before DONE: the cycle still runs to COMPLETE, then COMPLETE exits on the next cycle since REQ is already 0. REQ fields are never re-sampled mid-cycle.
- Timeout counter: 10 bits, cleared on entry to STROBE, saturating.

Decomposition:
- Shared package vme_pkg:
  - state encoding localparams S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_COMPLETE;
  - BUS_ERR_DATA = 16'hDEAD;
  - device-number constants (e.g. DEV_STATUS) used by the VME top level.
- One sub-module, vme_cycle_timer: loadable down/up counter with terminal flag. It is instanced twice, once for setup and once for timeout.

Test Plan:
- Read, device 3, CMD=0, SETUP_CYC=2; SLV_ACK[3] pulses 3 cycles after STROBE with SLV_RDATA=16'h7E1C -> STROBE rises 3 cycles after REQ, DONE=1, RDATA=16'h7E1C, TIMEOUT=0, DEVICE=8'h08 throughout until HOLD ends.
- Write, device 1, CMD=2, WDATA=16'hA5A5; SLV_ACK[1] answers -> INDATA=16'hA5A5 and WRITE_B=0 stable from SETUP through HOLD, RDATA unchanged, DONE=1.
- Read, device 5, no ACK, TIMEOUT_CYC=200 -> STROBE high exactly 200 cycles, then DONE=1, TIMEOUT=1, RDATA=16'hDEAD.
- Read, REQ_DEV=12 with NDEV=8 -> DEVICE and STROBE never assert; DONE=1 and TIMEOUT=1 within 2 cycles.
- Wrong-device ACK: SLV_ACK[2] pulses while device 4 is selected -> ignored; completion occurs only on SLV_ACK[4], or by timeout if it never comes.
- RST asserted during STROBE, then REQ held high -> next cycle all outputs at reset values and DONE never seen; the cycle restarts only after REQ goes 0 then 1.
